// File: rtl/exec_issue_ctrl_pkg.sv
// Shared execution-unit definitions: funct codes, NOP, issue FSM state encoding
// and small decode helpers used by the issue controller and the ALU control.
package exec_issue_ctrl_pkg;

    localparam int unsigned CNT_W = 6;

    localparam logic [5:0] FN_NOP  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_MFHI = 6'd16;
    localparam logic [5:0] FN_MFLO = 6'd18;
    localparam logic [5:0] FN_MULT = 6'd25;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_SLT  = 6'd42;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMulw,
        StHold
    } state_e;

    // Ops that produce a result beat through the ALU_LAT path.
    function automatic logic is_alu_op(input logic [5:0] funct);
        logic hit;
        case (funct)
            FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL, FN_MFHI, FN_MFLO: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic is_mult(input logic [5:0] funct);
        return funct == FN_MULT;
    endfunction

endpackage

// File: rtl/exec_issue_ctrl_if.sv
// Issue/result handshake and execution-unit operand bundle for exec_issue_ctrl.
interface exec_issue_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_funct;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    modport master (
        output in_valid, in_funct, in_a, in_b, alu_result, out_ready,
        input  in_ready, dataA, dataB, Signal, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_funct, in_a, in_b, alu_result, out_ready,
        output in_ready, dataA, dataB, Signal, out_valid, out_data, out_err
    );

endinterface

// File: rtl/exec_lat_counter.sv
// Loadable latency down-counter; saturates at zero and flags when empty.
module exec_lat_counter
    import exec_issue_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && value != '0) begin
            value <= value - CNT_W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/exec_issue_ctrl.sv
// Single-op-in-flight issue controller: latches an op, drives the execution unit
// for a fixed latency, captures the result and hands it downstream.
module exec_issue_ctrl
    import exec_issue_ctrl_pkg::*;
#(
    parameter int unsigned ALU_LAT    = 1,
    parameter int unsigned MUL_CYCLES = 32
) (
    input logic               clk,
    input logic               reset,
    exec_issue_ctrl_if.slave  bus
);

    state_e           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [31:0]      out_data_q;
    logic             out_err_q;
    logic [5:0]       sig_q;
    logic [31:0]      data_a_q;
    logic [31:0]      data_b_q;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;
    logic             cnt_dec;
    logic             cnt_done;

    always_comb begin
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        if (state == StIdle && bus.in_valid) begin
            if (is_mult(bus.in_funct)) begin
                cnt_load       = 1'b1;
                cnt_load_value = CNT_W'(MUL_CYCLES);
            end else if (is_alu_op(bus.in_funct)) begin
                cnt_load       = 1'b1;
                cnt_load_value = CNT_W'(ALU_LAT);
            end
        end
    end

    assign cnt_dec  = (state == StExec) || (state == StMulw);
    // Leave on the edge that takes the counter from 1 to 0.
    assign cnt_done = cnt_zero || (cnt_value == CNT_W'(1));

    exec_lat_counter u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .value      (cnt_value),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            sig_q       <= FN_NOP;
            data_a_q    <= '0;
            data_b_q    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        if (is_mult(bus.in_funct) || is_alu_op(bus.in_funct)) begin
                            state    <= is_mult(bus.in_funct) ? StMulw : StExec;
                            sig_q    <= bus.in_funct;
                            data_a_q <= bus.in_a;
                            data_b_q <= bus.in_b;
                        end else begin
                            state       <= StHold;
                            out_valid_q <= 1'b1;
                            out_data_q  <= '0;
                            out_err_q   <= 1'b1;
                        end
                    end
                end
                StExec: begin
                    if (cnt_done) begin
                        state       <= StHold;
                        out_valid_q <= 1'b1;
                        out_data_q  <= bus.alu_result;
                        out_err_q   <= 1'b0;
                        sig_q       <= FN_NOP;
                        data_a_q    <= '0;
                        data_b_q    <= '0;
                    end
                end
                StMulw: begin
                    // MULT only writes Hi/Lo inside the execution unit; no beat.
                    if (cnt_done) begin
                        state      <= StIdle;
                        in_ready_q <= 1'b1;
                        sig_q      <= FN_NOP;
                        data_a_q   <= '0;
                        data_b_q   <= '0;
                    end
                end
                StHold: begin
                    if (bus.out_ready) begin
                        state       <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.Signal    = sig_q;
    assign bus.dataA     = data_a_q;
    assign bus.dataB     = data_b_q;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Directed and randomized bench for exec_issue_ctrl with a behavioural execution
// unit and a funct-level reference model.
module tb_exec_issue_ctrl;

    localparam int unsigned ALU_LAT    = 1;
    localparam int unsigned MUL_CYCLES = 32;

    localparam logic [5:0] F_AND  = 6'd36;
    localparam logic [5:0] F_OR   = 6'd37;
    localparam logic [5:0] F_ADD  = 6'd32;
    localparam logic [5:0] F_SUB  = 6'd34;
    localparam logic [5:0] F_SLT  = 6'd42;
    localparam logic [5:0] F_SRL  = 6'd2;
    localparam logic [5:0] F_MULT = 6'd25;
    localparam logic [5:0] F_MFHI = 6'd16;
    localparam logic [5:0] F_MFLO = 6'd18;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exec_issue_ctrl_if bus();

    exec_issue_ctrl #(
        .ALU_LAT    (ALU_LAT),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          nchk = 0;
    int          nerr = 0;
    int          hs_cyc;
    int          mul_hs_cyc;
    logic [31:0] exp_hi, exp_lo;
    logic [31:0] eu_hi, eu_lo;

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return 64'(sa * sb);
    endfunction

    function automatic logic [31:0] alu_fn(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        logic [31:0] r;
        case (f)
            F_AND:   r = a & b;
            F_OR:    r = a | b;
            F_ADD:   r = a + b;
            F_SUB:   r = a - b;
            F_SLT:   r = {31'b0, $signed(a) < $signed(b)};
            F_SRL:   r = a >> b[4:0];
            F_MFHI:  r = hi;
            F_MFLO:  r = lo;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic supported(input logic [5:0] f);
        return f inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MULT, F_MFHI, F_MFLO};
    endfunction

    // Execution unit: combinational ALU, Hi/Lo written while MULT is issued.
    assign bus.alu_result = alu_fn(bus.Signal, bus.dataA, bus.dataB, eu_hi, eu_lo);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eu_hi <= '0;
            eu_lo <= '0;
        end else if (bus.Signal == F_MULT) begin
            {eu_hi, eu_lo} <= mul64(bus.dataA, bus.dataB);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_funct = f;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        hs_cyc = cyc;
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic complete(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            input int stall);
        int          n = 0;
        int          exp_n;
        logic        exp_e;
        logic [31:0] exp_d;
        exp_e = !supported(f);
        exp_d = exp_e ? 32'd0 : alu_fn(f, a, b, exp_hi, exp_lo);
        exp_n = exp_e ? 0 : int'(ALU_LAT);
        while (!bus.out_valid && n < 20) begin
            chk("sig_exec", 32'(bus.Signal), 32'(f));
            chk("dataA_exec", bus.dataA, a);
            chk("dataB_exec", bus.dataB, b);
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(exp_n));
        chk("out_data", bus.out_data, exp_d);
        chk("out_err", 32'(bus.out_err), 32'(exp_e));
        chk("sig_hold", 32'(bus.Signal), 32'd0);
        bus.out_ready = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_data", bus.out_data, exp_d);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            if (i == stall - 1) bus.out_ready = 1'b1;
        end
        @(negedge clk);
        chk("beat_drop", 32'(bus.out_valid), 32'd0);
        chk("back_idle", 32'(bus.in_ready), 32'd1);
    endtask

    // MULT, optionally with the next op already presented while the MULT runs.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic hold,
                           input logic [5:0] next_f);
        int n = 0;
        issue(F_MULT, a, b);
        mul_hs_cyc   = hs_cyc;
        bus.in_valid = hold;
        bus.in_funct = next_f;
        while (!bus.in_ready && n < 100) begin
            chk("mulw_no_beat", 32'(bus.out_valid), 32'd0);
            chk("sig_mulw", 32'(bus.Signal), 32'(F_MULT));
            @(negedge clk);
            n++;
        end
        chk("mulw_cycles", 32'(n), 32'(MUL_CYCLES));
        {exp_hi, exp_lo} = mul64(a, b);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_data"}, bus.out_data, 32'd0);
        chk({tag, "_out_err"}, 32'(bus.out_err), 32'd0);
        chk({tag, "_signal"}, 32'(bus.Signal), 32'd0);
        chk({tag, "_dataA"}, bus.dataA, 32'd0);
        chk({tag, "_dataB"}, bus.dataB, 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    logic [5:0]  b2b [4];
    logic [5:0]  pool [9];
    logic [5:0]  f;
    logic [31:0] ra, rb;
    int          prev_hs;

    initial begin
        b2b  = '{F_AND, F_OR, F_SLT, F_SRL};
        pool = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MULT, F_MFHI, F_MFLO};
        exp_hi = '0;
        exp_lo = '0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_funct  = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // ADD 5+7: beat one cycle after issue.
        issue(F_ADD, 32'd5, 32'd7);
        complete(F_ADD, 32'd5, 32'd7, 0);

        // SUB with downstream stalled for 5 cycles.
        issue(F_SUB, 32'd100, 32'd58);
        complete(F_SUB, 32'd100, 32'd58, 5);

        // MULT 3*4 with MFLO waiting upstream: interlocked until MULW ends.
        do_mult(32'd3, 32'd4, 1'b1, F_MFLO);
        issue(F_MFLO, 32'd0, 32'd0);
        chk("mflo_accept_cycle", 32'(hs_cyc - mul_hs_cyc), 32'(MUL_CYCLES + 1));
        complete(F_MFLO, 32'd0, 32'd0, 0);

        do_mult(32'hFFFF_FFFD, 32'd4, 1'b0, F_AND);
        issue(F_MFHI, 32'd0, 32'd0);
        complete(F_MFHI, 32'd0, 32'd0, 0);

        // Unsupported funct: error beat with zero data.
        issue(6'b111111, 32'd9, 32'd9);
        complete(6'b111111, 32'd9, 32'd9, 1);

        // Back-to-back ops with out_ready high.
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            prev_hs = hs_cyc;
            issue(b2b[i], ra, rb);
            if (i > 0) chk("b2b_period", 32'(hs_cyc - prev_hs), 32'(ALU_LAT + 2));
            complete(b2b[i], ra, rb, 0);
        end

        // Reset ten cycles into a MULT.
        issue(F_OR, 32'hF0F0, 32'h0F0F);
        complete(F_OR, 32'hF0F0, 32'h0F0F, 0);
        issue(F_MULT, 32'd1234, 32'd5678);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_zero_outputs("mid_mult_reset");
        @(negedge clk);
        reset  = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_no_beat", 32'(bus.out_valid), 32'd0);
        end
        issue(F_ADD, 32'd40, 32'd2);
        complete(F_ADD, 32'd40, 32'd2, 0);

        // Randomized op stream.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                f = 6'($urandom);
                while (supported(f)) f = 6'($urandom);
            end else begin
                f = pool[$urandom_range(0, 8)];
            end
            if (f == F_MULT) begin
                do_mult(ra, rb, 1'b0, F_AND);
            end else begin
                issue(f, ra, rb);
                complete(f, ra, rb, $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
